// File: rtl/anton_neopixel_stream_decoder_pkg.sv
// Shared constants for the NeoPixel stream decoder: FSM encoding, error bit
// positions, parameter defaults and the on-wire GRB to storage RGB remap.
package anton_neopixel_stream_decoder_pkg;

  localparam int BUFFER_END_DEFAULT    = 255;
  localparam int RESET_DELAY_DEFAULT   = 1920;
  localparam int ONE_THRESHOLD_DEFAULT = 4;
  localparam int HIGH_MAX_DEFAULT      = 7;

  localparam logic [2:0] DEC_SYNC  = 3'd0;
  localparam logic [2:0] DEC_IDLE  = 3'd1;
  localparam logic [2:0] DEC_HIGH  = 3'd2;
  localparam logic [2:0] DEC_LOW   = 3'd3;
  localparam logic [2:0] DEC_ERROR = 3'd4;

  localparam int ERR_TOO_LONG = 0;
  localparam int ERR_PARTIAL  = 1;
  localparam int ERR_OVERFLOW = 2;

  // Wire order is G,R,B; storage order is R,G,B.
  function automatic logic [1:0] grb_to_rgb(input logic [1:0] ch);
    case (ch)
      2'd0:    grb_to_rgb = 2'd1;
      2'd1:    grb_to_rgb = 2'd0;
      2'd2:    grb_to_rgb = 2'd2;
      default: grb_to_rgb = 2'd3;
    endcase
  endfunction

endpackage

// File: rtl/anton_neopixel_pulse_meter.sv
// Synchronizes the serial line and measures high/low run lengths, flagging
// bit boundaries, over-long pulses and the frame-terminating low period.
module anton_neopixel_pulse_meter #(
  parameter int RESET_DELAY   = 1920,
  parameter int ONE_THRESHOLD = 4,
  parameter int HIGH_MAX      = 7
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise,
  output logic bit_valid,
  output logic bit_value,
  output logic reset_seen,
  output logic too_long
);

  logic        meta;
  logic        s;
  logic        s_prev;
  logic [3:0]  high_run;
  logic [11:0] low_run;

  // Run counters hold the length of the run ending at the previous sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta     <= 1'b0;
      s        <= 1'b0;
      s_prev   <= 1'b0;
      high_run <= 4'd0;
      low_run  <= 12'd0;
    end else begin
      meta   <= din;
      s      <= meta;
      s_prev <= s;
      if (s) begin
        if (high_run != 4'hF) high_run <= high_run + 4'd1;
        low_run <= 12'd0;
      end else begin
        high_run <= 4'd0;
        if (low_run != 12'(RESET_DELAY)) low_run <= low_run + 12'd1;
      end
    end
  end

  always_comb begin
    rise       = s & ~s_prev;
    bit_valid  = ~s & s_prev;
    bit_value  = (high_run >= 4'(ONE_THRESHOLD));
    too_long   = s & (high_run >= 4'(HIGH_MAX));
    reset_seen = (low_run == 12'(RESET_DELAY));
  end

endmodule

// File: rtl/anton_neopixel_stream_decoder.sv
// WS2812-style receiver: decodes bits from pulse high-time, assembles bytes
// MSB-first and writes them to the pixel buffer in linear or 32-bit layout.
module anton_neopixel_stream_decoder
  import anton_neopixel_stream_decoder_pkg::*;
#(
  parameter int  BUFFER_END    = BUFFER_END_DEFAULT,
  parameter int  RESET_DELAY   = RESET_DELAY_DEFAULT,
  parameter int  ONE_THRESHOLD = ONE_THRESHOLD_DEFAULT,
  parameter int  HIGH_MAX      = HIGH_MAX_DEFAULT,
  localparam int BUFFER_BITS   = $clog2(BUFFER_END + 1)
) (
  input  logic                   clk6_4mhz,
  input  logic                   rst,
  input  logic                   din,
  input  logic                   enable,
  input  logic                   regCtrl32bit,
  input  logic                   regCtrlLimit,
  input  logic [12:0]            regMax,
  output logic                   wrEn,
  output logic [BUFFER_BITS-1:0] wrAddr,
  output logic [7:0]             wrData,
  output logic                   frameDone,
  output logic [BUFFER_BITS:0]   frameBytes,
  output logic [2:0]             errFlags
);

  logic [2:0]             state;
  logic                   rise, bit_valid, bit_value, reset_seen, too_long;
  logic [6:0]             byte_sr;
  logic [2:0]             bit_ix;
  logic [1:0]             chan;
  logic [BUFFER_BITS:0]   byte_ix;
  logic [BUFFER_BITS-2:0] pix;
  logic [BUFFER_BITS:0]   frame_cnt;
  logic [BUFFER_BITS-1:0] limit;
  logic [BUFFER_BITS-1:0] addr;
  logic                   over;
  logic                   unused_bits;

  assign unused_bits = ^regMax;

  anton_neopixel_pulse_meter #(
    .RESET_DELAY  (RESET_DELAY),
    .ONE_THRESHOLD(ONE_THRESHOLD),
    .HIGH_MAX     (HIGH_MAX)
  ) u_meter (
    .clk       (clk6_4mhz),
    .rst       (rst),
    .din       (din),
    .rise      (rise),
    .bit_valid (bit_valid),
    .bit_value (bit_value),
    .reset_seen(reset_seen),
    .too_long  (too_long)
  );

  // In 32-bit mode a whole pixel is accepted or rejected by its base address.
  always_comb begin
    limit = regCtrlLimit ? regMax[BUFFER_BITS-1:0] : BUFFER_BITS'(BUFFER_END);
    if (regCtrl32bit) begin
      addr = {pix[BUFFER_BITS-3:0], grb_to_rgb(chan)};
      over = (pix > {1'b0, limit[BUFFER_BITS-1:2]});
    end else begin
      addr = byte_ix[BUFFER_BITS-1:0];
      over = (byte_ix > {1'b0, limit});
    end
  end

  // Decoder FSM, byte assembly and buffer write port.
  always_ff @(posedge clk6_4mhz) begin
    if (rst) begin
      state      <= DEC_SYNC;
      byte_sr    <= 7'd0;
      bit_ix     <= 3'd0;
      chan       <= 2'd0;
      byte_ix    <= '0;
      pix        <= '0;
      frame_cnt  <= '0;
      wrEn       <= 1'b0;
      wrAddr     <= '0;
      wrData     <= 8'd0;
      frameDone  <= 1'b0;
      frameBytes <= '0;
      errFlags   <= 3'd0;
    end else begin
      wrEn      <= 1'b0;
      frameDone <= 1'b0;
      if (!enable) begin
        state <= DEC_SYNC;
      end else begin
        case (state)
          DEC_SYNC, DEC_ERROR: begin
            if (reset_seen) state <= DEC_IDLE;
          end
          DEC_IDLE: begin
            byte_sr   <= 7'd0;
            bit_ix    <= 3'd0;
            chan      <= 2'd0;
            byte_ix   <= '0;
            pix       <= '0;
            frame_cnt <= '0;
            errFlags  <= 3'd0;
            if (rise) state <= DEC_HIGH;
          end
          DEC_HIGH: begin
            if (too_long) begin
              errFlags[ERR_TOO_LONG] <= 1'b1;
              state <= DEC_ERROR;
            end else if (bit_valid) begin
              byte_sr <= {byte_sr[5:0], bit_value};
              bit_ix  <= bit_ix + 3'd1;
              state   <= DEC_LOW;
              if (bit_ix == 3'd7) begin
                wrData <= {byte_sr, bit_value};
                wrAddr <= addr;
                if (over) begin
                  errFlags[ERR_OVERFLOW] <= 1'b1;
                end else begin
                  wrEn      <= 1'b1;
                  frame_cnt <= frame_cnt + (BUFFER_BITS+1)'(1);
                end
                if (byte_ix != '1) byte_ix <= byte_ix + (BUFFER_BITS+1)'(1);
                if (chan == 2'd2) begin
                  chan <= 2'd0;
                  if (pix != '1) pix <= pix + (BUFFER_BITS-1)'(1);
                end else begin
                  chan <= chan + 2'd1;
                end
              end
            end
          end
          DEC_LOW: begin
            if (reset_seen) begin
              if (bit_ix != 3'd0) errFlags[ERR_PARTIAL] <= 1'b1;
              frameDone  <= 1'b1;
              frameBytes <= frame_cnt;
              state      <= DEC_IDLE;
            end else if (rise) begin
              state <= DEC_HIGH;
            end
          end
          default: state <= DEC_SYNC;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_anton_neopixel_stream_decoder.sv
// Randomized bench: pulse-level line driver, monitor of the write port and a
// byte-list reference model of addressing, limits and error flags.
module tb_anton_neopixel_stream_decoder;

  localparam int BE = 63;
  localparam int RD = 100;
  localparam int BB = $clog2(BE + 1);

  logic          clk = 1'b0;
  logic          rst, din, enable, regCtrl32bit, regCtrlLimit;
  logic [12:0]   regMax;
  logic          wrEn;
  logic [BB-1:0] wrAddr;
  logic [7:0]    wrData;
  logic          frameDone;
  logic [BB:0]   frameBytes;
  logic [2:0]    errFlags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  anton_neopixel_stream_decoder #(.BUFFER_END(BE), .RESET_DELAY(RD)) dut (
    .clk6_4mhz   (clk),
    .rst         (rst),
    .din         (din),
    .enable      (enable),
    .regCtrl32bit(regCtrl32bit),
    .regCtrlLimit(regCtrlLimit),
    .regMax      (regMax),
    .wrEn        (wrEn),
    .wrAddr      (wrAddr),
    .wrData      (wrData),
    .frameDone   (frameDone),
    .frameBytes  (frameBytes),
    .errFlags    (errFlags)
  );

  // Monitor, sampled on the falling edge.
  logic          mon_clr = 1'b0;
  logic [BB+7:0] got_wr[$];
  int            fd_count = 0;
  logic [BB:0]   fd_bytes = '0;
  logic [2:0]    fd_err = 3'b0;
  logic [2:0]    err_seen = 3'b0;

  always @(negedge clk) begin
    if (mon_clr) begin
      got_wr.delete();
      fd_count = 0;
      fd_bytes = '0;
      fd_err   = 3'b0;
      err_seen = 3'b0;
    end else begin
      if (wrEn) got_wr.push_back({wrAddr, wrData});
      if (frameDone) begin
        fd_count++;
        fd_bytes = frameBytes;
        fd_err   = errFlags;
      end
      err_seen |= errFlags;
    end
  end

  // Reference model state.
  logic [7:0]    tx[$];
  logic [BB+7:0] exp_wr[$];
  int            exp_bytes;
  logic [2:0]    exp_err;

  task automatic clear_mon();
    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
  endtask

  task automatic tick(input logic v, input int n);
    repeat (n) begin @(negedge clk); din = v; end
  endtask

  task automatic send_bit(input int hi, input int lo);
    tick(1'b1, hi);
    tick(1'b0, lo);
  endtask

  task automatic send_byte_rand(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) begin
      if (b[i]) send_bit(int'($urandom_range(7, 4)), int'($urandom_range(4, 1)));
      else      send_bit(int'($urandom_range(3, 1)), int'($urandom_range(6, 1)));
    end
  endtask

  // Expected writes from wire byte index: pixel = k/3, channel = k%3.
  task automatic model_frame(input bit m32, input bit len, input int lim, input int extra);
    int limv, pix, ch, slot, addr;
    bit ok;
    exp_wr.delete();
    exp_bytes = 0;
    exp_err   = 3'b0;
    limv = len ? (lim % (BE + 1)) : BE;
    foreach (tx[k]) begin
      if (m32) begin
        pix  = k / 3;
        ch   = k % 3;
        slot = (ch == 0) ? 1 : ((ch == 1) ? 0 : 2);
        addr = pix * 4 + slot;
        ok   = (pix * 4 <= limv - (limv % 4));
      end else begin
        addr = k;
        ok   = (k <= limv);
      end
      if (ok) begin
        exp_wr.push_back({addr[BB-1:0], tx[k]});
        exp_bytes++;
      end else begin
        exp_err[2] = 1'b1;
      end
    end
    if (extra != 0) exp_err[1] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({wrEn, frameDone, frameBytes, errFlags, wrAddr, wrData} !== '0) begin
      errors++;
      $display("FAIL reset outputs got wrEn=%b done=%b bytes=%0d err=%b addr=%0d data=%h want all 0",
               wrEn, frameDone, frameBytes, errFlags, wrAddr, wrData);
    end
    rst = 1'b0;
  endtask

  task automatic test_single_ff();
    regCtrl32bit = 1'b0; regCtrlLimit = 1'b0;
    tx = '{8'hFF};
    clear_mon();
    tick(1'b0, RD + 20);
    repeat (8) send_bit(5, 3);
    tick(1'b0, RD + 20);
    model_frame(1'b0, 1'b0, 0, 0);
    checks++;
    if (got_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL single_ff writes got %0d want %0d", got_wr.size(), exp_wr.size());
    end
    foreach (exp_wr[i]) if (i < got_wr.size()) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin
        errors++; $display("FAIL single_ff write%0d got %h want %h", i, got_wr[i], exp_wr[i]);
      end
    end
    checks++;
    if (fd_count != 1 || fd_bytes !== exp_bytes[BB:0] || fd_err !== exp_err) begin
      errors++;
      $display("FAIL single_ff frame got done=%0d bytes=%0d err=%b want done=1 bytes=%0d err=%b",
               fd_count, fd_bytes, fd_err, exp_bytes, exp_err);
    end
  endtask

  task automatic test_threshold();
    int hs[16] = '{4, 2, 4, 2, 2, 4, 4, 2, 7, 3, 7, 3, 1, 7, 3, 4};
    regCtrl32bit = 1'b0; regCtrlLimit = 1'b0;
    tx = '{8'hA6, 8'hA5};
    clear_mon();
    tick(1'b0, RD + 20);
    for (int i = 0; i < 16; i++) send_bit(hs[i], int'($urandom_range(5, 1)));
    tick(1'b0, RD + 20);
    model_frame(1'b0, 1'b0, 0, 0);
    checks++;
    if (got_wr.size() != exp_wr.size()) begin
      errors++; $display("FAIL threshold writes got %0d want %0d", got_wr.size(), exp_wr.size());
    end
    foreach (exp_wr[i]) if (i < got_wr.size()) begin
      checks++;
      if (got_wr[i] !== exp_wr[i]) begin
        errors++; $display("FAIL threshold write%0d got %h want %h", i, got_wr[i], exp_wr[i]);
      end
    end
    checks++;
    if (fd_count != 1 || fd_bytes !== exp_bytes[BB:0] || fd_err !== exp_err) begin
      errors++;
      $display("FAIL threshold frame got done=%0d bytes=%0d err=%b want done=1 bytes=%0d err=%b",
               fd_count, fd_bytes, fd_err, exp_bytes, exp_err);
    end
  endtask

  task automatic test_too_long();
    regCtrl32bit = 1'b0; regCtrlLimit = 1'b0;
    clear_mon();
    tick(1'b0, RD + 20);
    send_byte_rand(8'h3C);
    send_bit(8, 3);
    send_byte_rand(8'hFF);
    tick(1'b0, RD + 20);
    checks++;
    if (got_wr.size() != 1) begin
      errors++; $display("FAIL too_long writes got %0d want 1", got_wr.size());
    end else begin
      checks++;
      if (got_wr[0] !== {6'd0, 8'h3C}) begin
        errors++; $display("FAIL too_long write0 got %h want %h", got_wr[0], {6'd0, 8'h3C});
      end
    end
    checks++;
    if (fd_count != 0) begin
      errors++; $display("FAIL too_long frameDone got %0d want 0", fd_count);
    end
    checks++;
    if (err_seen[0] !== 1'b1) begin
      errors++; $display("FAIL too_long errFlags0 got %b want 1", err_seen[0]);
    end
  endtask

  task automatic test_enable_drop();
    regCtrl32bit = 1'b0; regCtrlLimit = 1'b0;
    clear_mon();
    tick(1'b0, RD + 20);
    send_byte_rand(8'hC3);
    repeat (3) send_bit(5, 3);
    @(negedge clk); enable = 1'b0;
    send_byte_rand(8'h99);
    @(negedge clk); enable = 1'b1;
    send_byte_rand(8'h66);
    tick(1'b0, RD + 20);
    checks++;
    if (got_wr.size() != 1) begin
      errors++; $display("FAIL enable_drop writes got %0d want 1", got_wr.size());
    end else begin
      checks++;
      if (got_wr[0] !== {6'd0, 8'hC3}) begin
        errors++; $display("FAIL enable_drop write0 got %h want %h", got_wr[0], {6'd0, 8'hC3});
      end
    end
    checks++;
    if (fd_count != 0) begin
      errors++; $display("FAIL enable_drop frameDone got %0d want 0", fd_count);
    end
  endtask

  task automatic test_rst_mid();
    regCtrl32bit = 1'b0; regCtrlLimit = 1'b0;
    clear_mon();
    tick(1'b0, RD + 20);
    repeat (5) send_bit(5, 3);
    @(negedge clk); rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({wrEn, frameDone, frameBytes, errFlags} !== '0) begin
      errors++;
      $display("FAIL rst_mid outputs got wrEn=%b done=%b bytes=%0d err=%b want 0",
               wrEn, frameDone, frameBytes, errFlags);
    end
    rst = 1'b0;
    send_byte_rand(8'h5A);
    tick(1'b0, RD + 20);
    checks++;
    if (got_wr.size() != 0) begin
      errors++; $display("FAIL rst_mid writes got %0d want 0", got_wr.size());
    end
    checks++;
    if (fd_count != 0) begin
      errors++; $display("FAIL rst_mid frameDone got %0d want 0", fd_count);
    end
  endtask

  // Table of framed cases: GRB remap, software limit, partial byte, then random.
  task automatic test_modes();
    bit    m32, len;
    int    extra, n;
    string name;
    for (int c = 0; c < 12; c++) begin
      tx.delete();
      extra = 0;
      case (c)
        0: begin
          name = "grb_remap"; m32 = 1'b1; len = 1'b0; regMax = 13'd0;
          tx = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h9A, 8'hBC};
        end
        1: begin
          name = "limit"; m32 = 1'b0; len = 1'b1; regMax = 13'd2;
          repeat (4) tx.push_back(8'($urandom));
        end
        2: begin
          name = "partial"; m32 = 1'b0; len = 1'b0; regMax = 13'd0; extra = 4;
          tx.push_back(8'($urandom));
        end
        default: begin
          name = "random"; m32 = 1'($urandom); len = 1'($urandom);
          regMax = 13'($urandom);
          n = int'($urandom_range(9, 1));
          repeat (n) tx.push_back(8'($urandom));
        end
      endcase
      regCtrl32bit = m32; regCtrlLimit = len;
      clear_mon();
      tick(1'b0, RD + 20);
      foreach (tx[k]) send_byte_rand(tx[k]);
      repeat (extra) begin
        if ($urandom_range(1, 0) == 1) send_bit(5, 3);
        else                           send_bit(2, 5);
      end
      tick(1'b0, RD + 20);
      model_frame(m32, len, int'(regMax), extra);
      checks++;
      if (got_wr.size() != exp_wr.size()) begin
        errors++; $display("FAIL %s case%0d writes got %0d want %0d", name, c, got_wr.size(), exp_wr.size());
      end
      foreach (exp_wr[i]) if (i < got_wr.size()) begin
        checks++;
        if (got_wr[i] !== exp_wr[i]) begin
          errors++; $display("FAIL %s case%0d write%0d got %h want %h", name, c, i, got_wr[i], exp_wr[i]);
        end
      end
      checks++;
      if (fd_count != 1 || fd_bytes !== exp_bytes[BB:0] || fd_err !== exp_err) begin
        errors++;
        $display("FAIL %s case%0d frame got done=%0d bytes=%0d err=%b want done=1 bytes=%0d err=%b",
                 name, c, fd_count, fd_bytes, fd_err, exp_bytes, exp_err);
      end
    end
  endtask

  initial begin
    din = 1'b0; rst = 1'b1; enable = 1'b1;
    regCtrl32bit = 1'b0; regCtrlLimit = 1'b0; regMax = 13'd0;
    test_reset();
    test_single_ff();
    test_threshold();
    test_too_long();
    test_modes();
    test_enable_drop();
    test_rst_mid();
    test_modes();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/anton_neopixel_stream_decoder.md
Name: anton_neopixel_stream_decoder

Overview:
Receive-side counterpart of the NeoPixel stream transmitter. Samples a WS2812-style serial line on the 6.4MHz clock, decodes each bit from its high-time, assembles bytes MSB-first, and remaps the on-wire GRB channel order to RGB. Writes each decoded byte into the pixel buffer write port and reports frame completion when the line idles low for the reset period. Used for loopback self-test and for chaining controllers.

Parameters:
BUFFER_END, `BUFFER_END_DEFAULT, last valid buffer byte address; BUFFER_BITS = `CLOG2(BUFFER_END+1) (localparam)
RESET_DELAY, `RESET_DELAY_DEFAULT, low ticks that terminate a frame (12-bit counter)
ONE_THRESHOLD, 4, high-time ticks at or above which a bit decodes as 1
HIGH_MAX, 7, high-time ticks above which the pulse is a protocol error

Ports:
clk6_4mhz  in  1  sample clock, 8 ticks per 800kHz bit
rst  in  1  synchronous active-high reset
din  in  1  serial line, asynchronous to clk6_4mhz
enable  in  1  decoder run; when low, FSM is held in SYNC
regCtrl32bit  in  1  1 = {pixel[BUFFER_BITS-1:2], remapped channel} addressing; 0 = linear byte addressing
regCtrlLimit  in  1  1 = use regMax as the last address; 0 = use BUFFER_END
regMax  in  13  software address limit
wrEn  out  1  one-cycle byte write strobe
wrAddr  out  BUFFER_BITS  byte address
wrData  out  8  decoded byte
frameDone  out  1  one-cycle pulse at a valid frame end
frameBytes  out  BUFFER_BITS+1  bytes written in the last frame, held until the next frameDone
errFlags  out  3  sticky per frame: [0] pulse too long, [1] partial byte at frame end, [2] buffer overflow

Behaviour:
- Reset: all outputs 0; FSM SYNC; all counters 0.
- din passes through a 2-flop synchronizer. All edge and level references below use the synchronized value s.
- FSM states: SYNC, IDLE, HIGH, LOW, ERROR.
  - SYNC: count consecutive low ticks. When count reaches RESET_DELAY, go to IDLE. Any high sample clears the count.
  - IDLE: clear address, byte, bit and channel counters and errFlags. On s rising, go to HIGH with highCnt=1.
  - HIGH: highCnt++ each tick.
    - If highCnt exceeds HIGH_MAX: set errFlags[0] and go to ERROR.
    - On s low: decode bit = (highCnt >= ONE_THRESHOLD) and shift it into the byte LSB, so the first bit is the MSB. Go to LOW with lowCnt=1.
  - LOW: lowCnt++ each tick.
    - On s rising: go to HIGH.
    - When lowCnt reaches RESET_DELAY: set errFlags[1] if bitIx != 0, pulse frameDone, latch frameBytes, go to IDLE.
  - ERROR: behaves like SYNC, but does not pulse frameDone. errFlags stay set until the next IDLE entry.
- Byte assembly:
  - The 8th bit completes a byte. wrEn is asserted the cycle after the HIGH->LOW transition of that bit.
  - wrData is the full byte. wrAddr is registered with wrData.
- Channel handling:
  - The wire channel counter cycles 0,1,2, wrapping after 2.
  - Remap to storage order: 0->1, 1->0, 2->2.
- Addressing:
  - 8-bit mode: wrAddr = byteIx, incremented per byte.
  - 32-bit mode: wrAddr = {pixelIx[BUFFER_BITS-1:2], remapped channel}. pixelIx advances by 4 after channel 2.
  - Limit = regCtrlLimit ? regMax[BUFFER_BITS-1:0] : BUFFER_END. In 32-bit mode the limit is compared with its low 2 bits cleared.
  - A byte whose address exceeds the limit is not written: wrEn stays low, errFlags[2] is set, frameBytes is not incremented. Decoding continues until reset.
- enable low mid-frame: go to SYNC next cycle. No frameDone pulse. Any byte already written stays written.
- rst mid-operation overrides everything.
- Simultaneous events:
  - frameDone and a write never coincide, since the reset period is much longer than write latency.
  - A rising edge on the same tick lowCnt reaches RESET_DELAY: the frame end wins, then the edge is ignored (IDLE waits for the next rising edge).

Decomposition:
- Add to anton_common.vh: state enum `ENUM_DEC_SYNC/IDLE/HIGH/LOW/ERROR, ERR_* bit indices, ONE_THRESHOLD/HIGH_MAX defaults.
- Share the GRB->RGB remap with the transmitter; move it to anton_common.vh as a function macro.
- One natural sub-module: anton_neopixel_pulse_meter (synchronizer plus high/low run-length counters, emitting bitValid/bitValue/resetSeen/tooLong). The FSM and addressing stay in the top.

Test Plan:
1. Line low for 2000 ticks, then pulses high 5/low 3, repeated 8 times, then low 2000 -> one write, wrData=8'hFF, wrAddr=0, frameDone pulse, frameBytes=1, errFlags=0.
2. Two pixels, wire bytes G=0x12 R=0x34 B=0x56 / 0x78 0x9A 0xBC, 32-bit mode -> writes addr0=0x34, addr1=0x12, addr2=0x56, addr4=0x9A, addr5=0x78, addr6=0xBC; frameBytes=6.
3. High-time 2 -> bit 0; high-time 4 -> bit 1 (threshold boundary); high-time 8 -> errFlags[0]=1, no frameDone, recovery after 2000 low.
4. regCtrlLimit=1, regMax=2, 8-bit mode, 4 bytes sent -> writes to addr 0..2 only, errFlags[2]=1, frameBytes=3.
5. 12 bits then low 2000 -> one write, errFlags[1]=1, frameDone pulses.
6. enable dropped after byte 1, and separately rst asserted mid-byte -> no further writes, no frameDone, next frame decodes from addr 0 after SYNC.
